// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_capture_pkg                                                      |
// | Shared types and constants for the PWM capture block.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package pwm_capture_pkg;

    localparam int c_CNT_W_DEFAULT = 32;

    // Polarity encoding shared with pwm_module
    localparam logic PWM_POL_HIGH = 1'b0;
    localparam logic PWM_POL_LOW  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_INACTIVE = 2'd3
    } pwm_cap_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_in_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_in_cond                                                          |
// | Input synchronizer, optional glitch filter (PWM_CAPTURE_GLITCH_      |
// | FILTER_EN), polarity normalization and registered edge detection.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pwm_in_cond
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm_in,
    input  logic i_polar,
    output logic o_s_lvl,
    output logic o_rise,
    output logic o_fall
);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam bit c_FILT_EN = 1'b1;
`else
    localparam bit c_FILT_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_raw;
    logic                   w_filt;
    logic                   w_lvl;
    logic                   r_lvl_q;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
        end
    end

    assign w_raw = r_sync[SYNC_STAGES-1];

    generate
        if (c_FILT_EN && (FILT_LEN > 0)) begin : g_filt
            localparam int                c_FW   = $clog2(FILT_LEN + 1);
            localparam logic [c_FW-1:0]   c_LAST = c_FW'(FILT_LEN - 1);
            localparam logic [c_FW-1:0]   c_ONE  = c_FW'(1);
            logic [c_FW-1:0] r_cnt;
            logic            r_filt;

            // Any return to the current level restarts the stability count
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (w_raw == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt == c_LAST) begin
                    r_filt <= w_raw;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + c_ONE;
                end
            end
            assign w_filt = r_filt;
        end else begin : g_no_filt
            assign w_filt = w_raw;
        end
    endgenerate

    assign w_lvl = w_filt ^ (i_polar == PWM_POL_LOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_q <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_lvl_q <= w_lvl;
            r_rise  <= w_lvl & ~r_lvl_q;
            r_fall  <= ~w_lvl & r_lvl_q;
        end
    end

    assign o_s_lvl = w_lvl;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_capture                                                          |
// | Measures period and active width of a PWM input in clock cycles.     |
// | Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             i_sysclk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_polar,
    input  logic [CNT_W-1:0] i_timeout_cnt,
    input  logic             i_pwm_in,
    output logic [CNT_W-1:0] o_period_cnt,
    output logic [CNT_W-1:0] o_duty_cnt,
    output logic             o_valid,
    output logic             o_timeout,
    output logic             o_stuck_level,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    pwm_cap_state_t   r_state;
    logic             r_pol;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;
    logic             r_valid;
    logic             r_timeout;
    logic             r_stuck;

    logic             w_lvl;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic             w_tmo;
    logic [CNT_W-1:0] w_per_inc;
    logic [CNT_W-1:0] w_idle_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + c_ONE;
    endfunction

    pwm_in_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_in_cond (
        .clk      (i_sysclk),
        .rst      (i_reset),
        .i_pwm_in (i_pwm_in),
        .i_polar  (r_pol),
        .o_s_lvl  (w_lvl),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    assign w_edge     = w_rise | w_fall;
    assign w_per_inc  = sat_inc(r_per_cnt);
    assign w_idle_inc = sat_inc(r_idle_cnt);
    // Excluding edge cycles lets a coincident rise win over the timeout
    assign w_tmo = (r_state != ST_IDLE) && (i_timeout_cnt != '0) && !w_edge &&
                   (w_idle_inc == i_timeout_cnt);

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_pol      <= PWM_POL_HIGH;
            r_per_cnt  <= '0;
            r_duty_sh  <= '0;
            r_idle_cnt <= '0;
            r_period   <= '0;
            r_duty     <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_stuck    <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_pol <= i_polar;
            end
            r_idle_cnt <= ((r_state == ST_IDLE) || w_edge || w_tmo) ? '0 : w_idle_inc;

            if (!i_enable) begin
                r_state   <= ST_IDLE;
                r_per_cnt <= '0;
            end else if (w_tmo) begin
                r_timeout <= 1'b1;
                r_stuck   <= w_lvl;
                r_period  <= '0;
                r_duty    <= {CNT_W{w_lvl}};
                r_per_cnt <= '0;
                r_state   <= ST_ARM;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_per_cnt <= c_ONE;
                            r_state   <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        r_per_cnt <= w_per_inc;
                        if (w_fall) begin
                            r_duty_sh <= r_per_cnt;
                            r_state   <= ST_INACTIVE;
                        end
                    end
                    ST_INACTIVE: begin
                        if (w_rise) begin
                            r_period  <= r_per_cnt;
                            r_duty    <= r_duty_sh;
                            r_valid   <= 1'b1;
                            r_per_cnt <= c_ONE;
                            r_state   <= ST_ACTIVE;
                        end else begin
                            r_per_cnt <= w_per_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_period_cnt  = r_period;
    assign o_duty_cnt    = r_duty;
    assign o_valid       = r_valid;
    assign o_timeout     = r_timeout;
    assign o_stuck_level = r_stuck;
    assign o_busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_capture                                                       |
// | Directed, table-driven bench for pwm_capture.                        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pwm_capture;
    import pwm_capture_pkg::*;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int c_LAT = 4 + 4;
`else
    localparam int c_LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst, en, en8, polar, pwm;
    logic [31:0] tmo;
    logic [31:0] per, duty;
    logic        valid, tout, stuck, busy;
    logic [7:0]  p8, d8;
    logic        v8, to8, st8, b8;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [31:0] per;
        logic [31:0] duty;
    } res_t;

    typedef struct {
        logic        pol;
        int          h;
        int          p;
        int          n;
        logic [31:0] ed;
        logic [31:0] ep;
    } vec_t;

    res_t vq[$];
    res_t vq8[$];
    int   toq[$];
    vec_t vt[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture #(.CNT_W(32), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
        .i_sysclk(clk), .i_reset(rst), .i_enable(en), .i_polar(polar),
        .i_timeout_cnt(tmo), .i_pwm_in(pwm), .o_period_cnt(per), .o_duty_cnt(duty),
        .o_valid(valid), .o_timeout(tout), .o_stuck_level(stuck), .o_busy(busy)
    );

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2), .FILT_LEN(4)) dut8 (
        .i_sysclk(clk), .i_reset(rst), .i_enable(en8), .i_polar(polar),
        .i_timeout_cnt(8'd0), .i_pwm_in(pwm), .o_period_cnt(p8), .o_duty_cnt(d8),
        .o_valid(v8), .o_timeout(to8), .o_stuck_level(st8), .o_busy(b8)
    );

    always @(negedge clk) begin
        if (valid) vq.push_back('{cyc: cyc, per: per, duty: duty});
        if (tout)  toq.push_back(cyc);
        if (v8)    vq8.push_back('{cyc: cyc, per: {24'd0, p8}, duty: {24'd0, d8}});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        en8 = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(6);
    endtask

    // One period: active level for h cycles, inactive for p-h; returns rise cycle
    task automatic period(input int h, input int p, input logic act, output int t_rise);
        pwm    = act;
        t_rise = cyc;
        tick(h);
        pwm = ~act;
        tick(p - h);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, t1, tlast;
        logic act;

        vt[0] = '{1'b0,  8, 16, 3, 32'd8,  32'd16};
        vt[1] = '{1'b1,  5, 16, 2, 32'd5,  32'd16};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        vt[2] = '{1'b0,  4,  8, 3, 32'd4,  32'd8};
`else
        vt[2] = '{1'b0,  1,  2, 3, 32'd1,  32'd2};
`endif
        vt[3] = '{1'b0,  6, 11, 2, 32'd6,  32'd11};
        vt[4] = '{1'b1, 10, 13, 2, 32'd10, 32'd13};

        rst = 1'b1; en = 1'b0; en8 = 1'b0; polar = PWM_POL_HIGH; pwm = 1'b0; tmo = 32'd0;
        tick(1);

        // Table-driven captures
        for (int i = 0; i < 5; i++) begin
            polar = vt[i].pol;
            act   = ~vt[i].pol;
            pwm   = vt[i].pol;
            do_reset();
            if (i == 0) begin
                chk("reset_period", per, 32'd0);
                chk("reset_duty",   duty, 32'd0);
                chk("reset_valid",  {31'd0, valid}, 32'd0);
                chk("reset_tout",   {31'd0, tout}, 32'd0);
                chk("reset_stuck",  {31'd0, stuck}, 32'd0);
                chk("reset_busy",   {31'd0, busy}, 32'd0);
            end
            en = 1'b1;
            tick(4);
            vq.delete();
            t1 = 0;
            for (int k = 0; k < vt[i].n; k++) begin
                period(vt[i].h, vt[i].p, act, t);
                if (k == 1) t1 = t;
            end
            pwm = act;
            tick(vt[i].h);
            pwm = ~act;
            tick(c_LAT + 4);
            chk($sformatf("vec%0d_count", i), vq.size(), vt[i].n);
            for (int j = 0; j < vq.size(); j++) begin
                chk($sformatf("vec%0d_duty%0d", i, j), vq[j].duty, vt[i].ed);
                chk($sformatf("vec%0d_period%0d", i, j), vq[j].per, vt[i].ep);
                if (j > 0)
                    chk($sformatf("vec%0d_spacing%0d", i, j), vq[j].cyc - vq[j-1].cyc, vt[i].p);
            end
            if (vq.size() > 0)
                chk($sformatf("vec%0d_first_latency", i), vq[0].cyc, t1 + c_LAT);
            en = 1'b0;
            tick(2);
        end

        // Timeout on a stuck-active input, then recovery
        polar = PWM_POL_HIGH; pwm = 1'b0;
        do_reset();
        tmo = 32'd100;
        en  = 1'b1;
        tick(4);
        vq.delete();
        toq.delete();
        period(8, 16, 1'b1, t);
        period(8, 16, 1'b1, t);
        pwm   = 1'b1;
        tlast = cyc;
        tick(c_LAT + 99);
        chk("tmo_not_early", {31'd0, tout}, 32'd0);
        tick(1);
        chk("tmo_pulse",  {31'd0, tout}, 32'd1);
        chk("tmo_stuck",  {31'd0, stuck}, 32'd1);
        chk("tmo_duty",   duty, 32'hFFFF_FFFF);
        chk("tmo_period", per, 32'd0);
        chk("tmo_busy",   {31'd0, busy}, 32'd1);
        tick(40);
        chk("tmo_count", toq.size(), 1);
        if (toq.size() > 0) chk("tmo_cycle", toq[0], tlast + c_LAT + 100);
        chk("tmo_valid_before", vq.size(), 2);
        pwm = 1'b0;
        tick(8);
        vq.delete();
        period(8, 16, 1'b1, t);
        period(8, 16, 1'b1, t);
        pwm = 1'b1;
        tick(c_LAT + 2);
        chk("tmo_resume_count", vq.size(), 2);
        if (vq.size() > 0) begin
            chk("tmo_resume_period", vq[0].per, 32'd16);
            chk("tmo_resume_duty",   vq[0].duty, 32'd8);
        end
        tmo = 32'd0;

        // Disable mid-ACTIVE: no strobe, results held
        pwm = 1'b0;
        do_reset();
        en = 1'b1;
        tick(4);
        vq.delete();
        period(8, 16, 1'b1, t);
        period(8, 16, 1'b1, t);
        pwm = 1'b1;
        tick(c_LAT + 2);
        en = 1'b0;
        tick(1);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        tick(5);
        pwm = 1'b0; tick(8);
        pwm = 1'b1; tick(c_LAT + 6);
        chk("dis_count",  vq.size(), 2);
        chk("dis_period", per, 32'd16);
        chk("dis_duty",   duty, 32'd8);

        // Reset mid-INACTIVE: no strobe, results cleared, re-arm needed
        pwm = 1'b0;
        do_reset();
        en = 1'b1;
        tick(4);
        vq.delete();
        period(8, 16, 1'b1, t);
        pwm = 1'b1; tick(8);
        pwm = 1'b0; tick(c_LAT + 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_period", per, 32'd0);
        chk("rst_duty",   duty, 32'd0);
        tick(3);
        pwm = 1'b1; tick(8);
        pwm = 1'b0; tick(8);
        chk("rst_no_valid", vq.size(), 1);
        pwm = 1'b1; tick(c_LAT + 2);
        chk("rst_rearm_count", vq.size(), 2);
        if (vq.size() > 1) chk("rst_rearm_period", vq[1].per, 32'd16);
        en = 1'b0;

        // Saturation with an 8-bit counter
        pwm = 1'b0;
        do_reset();
        en8 = 1'b1;
        tick(4);
        vq8.delete();
        period(100, 300, 1'b1, t);
        pwm = 1'b1;
        tick(c_LAT + 2);
        chk("sat_count", vq8.size(), 1);
        if (vq8.size() > 0) begin
            chk("sat_period", vq8[0].per, 32'd255);
            chk("sat_duty",   vq8[0].duty, 32'd100);
        end
        en8 = 1'b0;

        // 2-cycle glitch in the inactive part of an H=20, P=40 wave
        pwm = 1'b0;
        do_reset();
        en = 1'b1;
        tick(4);
        vq.delete();
        period(20, 40, 1'b1, t);
        pwm = 1'b1; tick(20);
        pwm = 1'b0; tick(10);
        pwm = 1'b1; tick(2);
        pwm = 1'b0; tick(8);
        pwm = 1'b1; tick(c_LAT + 2);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        chk("glitch_count", vq.size(), 2);
        if (vq.size() > 1) begin
            chk("glitch_period", vq[1].per, 32'd40);
            chk("glitch_duty",   vq[1].duty, 32'd20);
        end
`else
        chk("glitch_count", vq.size(), 3);
        if (vq.size() > 2) begin
            chk("glitch_period1", vq[1].per, 32'd30);
            chk("glitch_duty1",   vq[1].duty, 32'd20);
            chk("glitch_period2", vq[2].per, 32'd10);
            chk("glitch_duty2",   vq[2].duty, 32'd2);
        end
`endif
        if (vq.size() > 0) chk("glitch_clean_period", vq[0].per, 32'd40);
        en = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
